// File: rtl/tmr_alu_pkg.sv
// Shared opcodes, lane health states and opcode decode for the TMR ALU pipeline.
package tmr_alu_pkg;

   localparam logic [2:0] OP_ADD    = 3'b001;
   localparam logic [2:0] OP_SUB_AB = 3'b010;
   localparam logic [2:0] OP_SUB_BA = 3'b100;

   typedef enum logic [1:0] {
      HEALTHY = 2'd0,
      SUSPECT = 2'd1,
      FAILED  = 2'd2
   } lane_state_t;

   function automatic logic op_legal(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB_AB) || (op == OP_SUB_BA);
   endfunction

endpackage

// File: rtl/tmr_alu_pipe_if.sv
// Operand and result handshake bundle between the operand source, the TMR ALU and the result consumer.
interface tmr_alu_pipe_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             corrected;
   logic             uncorr;
   logic             op_err;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, result, cout, corrected, uncorr, op_err
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, result, cout, corrected, uncorr, op_err
   );
endinterface

// File: rtl/tmr_lane_monitor.sv
// Health tracker for one ALU lane: counts consecutive disagreements with the vote.
//
// state   | meaning
// HEALTHY | last counted result agreed with the vote
// SUSPECT | one or more consecutive mismatches, remain = mismatches left before FAILED
// FAILED  | lane declared bad; sticky until rst or clr
module tmr_lane_monitor
   import tmr_alu_pkg::*;
#(
   parameter int FAIL_THRESH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic update,
   input  logic mismatch,
   input  logic clr,
   output logic failed
);
   localparam int RW = (FAIL_THRESH > 1) ? $clog2(FAIL_THRESH) : 1;
   localparam logic [RW-1:0] RUN_LOAD = RW'(FAIL_THRESH - 1);

   lane_state_t   state;
   logic [RW-1:0] remain;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         state  <= HEALTHY;
         remain <= '0;
         failed <= 1'b0;
      end else if (update) begin
         case (state)
            HEALTHY: begin
               if (mismatch) begin
                  if (FAIL_THRESH == 1) begin
                     state  <= FAILED;
                     failed <= 1'b1;
                  end else begin
                     state  <= SUSPECT;
                     remain <= RUN_LOAD;
                  end
               end
            end
            SUSPECT: begin
               if (!mismatch) begin
                  state  <= HEALTHY;
                  remain <= '0;
               end else if (remain == RW'(1)) begin
                  state  <= FAILED;
                  remain <= '0;
                  failed <= 1'b1;
               end else begin
                  remain <= remain - RW'(1);
               end
            end
            FAILED: begin
               failed <= 1'b1;
            end
            default: begin
               state  <= HEALTHY;
               remain <= '0;
               failed <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/tmr_alu_pipe.sv
// Two-stage triple-redundant add/subtract ALU with bitwise majority vote,
// lane health tracking and a saturating corrected-error counter.
module tmr_alu_pipe
   import tmr_alu_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int FAIL_THRESH = 4,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   tmr_alu_pipe_if.slave    bus,
   input  logic [2:0]       inj_lane,
   input  logic [WIDTH:0]   inj_mask,
   input  logic             clr_fault,
   output logic [2:0]       lane_failed,
   output logic [CNT_W-1:0] err_cnt
);
   localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

   function automatic logic [WIDTH:0] lane_calc(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [2:0]       op);
      logic [WIDTH:0] r;
      r = '0;
      case (op)
         OP_ADD:    r = {1'b0, a}  + {1'b0, b};
         OP_SUB_AB: r = {1'b0, a}  + {1'b0, ~b} + ONE;
         OP_SUB_BA: r = {1'b0, ~a} + {1'b0, b}  + ONE;
         default:   r = '0;
      endcase
      return r;
   endfunction

   logic                 en;
   logic                 legal;
   logic [2:0][WIDTH:0]  lane_w;
   logic [2:0][WIDTH:0]  s1_w;
   logic                 s1_valid;
   logic                 s1_op_err;
   logic [WIDTH:0]       voted;
   logic [2:0]           mm;
   logic                 uncorr_w;
   logic                 corr_w;
   logic                 adv;

   logic                 out_valid_q;
   logic [WIDTH-1:0]     result_q;
   logic                 cout_q;
   logic                 corr_q;
   logic                 uncorr_q;
   logic                 op_err_q;

   assign en           = ~out_valid_q | bus.out_ready;
   assign bus.in_ready = en;
   assign legal        = op_legal(bus.op);

   // Each lane evaluates independently; injection models a fault inside one lane's adder.
   always_comb begin
      lane_w = '0;
      for (int i = 0; i < 3; i++) begin
         lane_w[i] = lane_calc(bus.a, bus.b, bus.op) ^ (inj_lane[i] ? inj_mask : '0);
      end
   end

   always_comb begin
      voted    = (s1_w[0] & s1_w[1]) | (s1_w[0] & s1_w[2]) | (s1_w[1] & s1_w[2]);
      mm       = '0;
      for (int i = 0; i < 3; i++) begin
         mm[i] = (s1_w[i] != voted);
      end
      uncorr_w = (s1_w[0] != s1_w[1]) && (s1_w[0] != s1_w[2]) && (s1_w[1] != s1_w[2]);
      corr_w   = (|mm) & ~uncorr_w;
      adv      = en & s1_valid & ~s1_op_err & ~uncorr_w;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid    <= 1'b0;
         s1_w        <= '0;
         s1_op_err   <= 1'b0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         cout_q      <= 1'b0;
         corr_q      <= 1'b0;
         uncorr_q    <= 1'b0;
         op_err_q    <= 1'b0;
      end else if (en) begin
         s1_valid    <= bus.in_valid;
         s1_w        <= lane_w;
         s1_op_err   <= ~legal;
         out_valid_q <= s1_valid;
         {cout_q, result_q} <= voted;
         corr_q      <= s1_valid & corr_w;
         uncorr_q    <= s1_valid & uncorr_w;
         op_err_q    <= s1_valid & s1_op_err;
      end
   end

   // A clear in the same cycle as a counted event wins.
   always_ff @(posedge clk) begin
      if (rst || clr_fault) begin
         err_cnt <= '0;
      end else if (adv && corr_w && (err_cnt != {CNT_W{1'b1}})) begin
         err_cnt <= err_cnt + 1'b1;
      end
   end

   for (genvar i = 0; i < 3; i++) begin : g_mon
      tmr_lane_monitor #(
         .FAIL_THRESH (FAIL_THRESH)
      ) u_mon (
         .clk      (clk),
         .rst      (rst),
         .update   (adv),
         .mismatch (mm[i]),
         .clr      (clr_fault),
         .failed   (lane_failed[i])
      );
   end

   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.cout      = cout_q;
   assign bus.corrected = corr_q;
   assign bus.uncorr    = uncorr_q;
   assign bus.op_err    = op_err_q;

endmodule

// File: tb/tb_tmr_alu_pipe.sv
// Bench for tmr_alu_pipe: table vectors through a scoreboard plus stall, reset, forced-vote and saturation sequences.
module tb_tmr_alu_pipe;
   import tmr_alu_pkg::*;

   localparam int WIDTH = 8;
   localparam int CNT_W = 8;

   typedef struct packed {
      logic [7:0] result;
      logic       cout;
      logic       corrected;
      logic       uncorr;
      logic       op_err;
      logic [2:0] lane_failed;
      logic [7:0] err_cnt;
   } exp_t;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] op;
      logic [2:0] inj_lane;
      logic [8:0] inj_mask;
      exp_t       exp;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [2:0]       inj_lane;
   logic [WIDTH:0]   inj_mask;
   logic             clr_fault;
   logic [2:0]       lane_failed;
   logic [CNT_W-1:0] err_cnt;

   tmr_alu_pipe_if #(.WIDTH(WIDTH)) bus ();

   tmr_alu_pipe #(
      .WIDTH       (WIDTH),
      .FAIL_THRESH (4),
      .CNT_W       (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus.slave),
      .inj_lane    (inj_lane),
      .inj_mask    (inj_mask),
      .clr_fault   (clr_fault),
      .lane_failed (lane_failed),
      .err_cnt     (err_cnt)
   );

   always #5 clk = ~clk;

   vec_t vecs[13];
   vec_t svec[5];
   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;

   function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                               input logic [2:0] inj, input logic [8:0] mask,
                               input logic [7:0] res, input logic c, input logic corr,
                               input logic unc, input logic oe, input logic [2:0] lf,
                               input logic [7:0] ec);
      vec_t v;
      v.a                 = a;
      v.b                 = b;
      v.op                = op;
      v.inj_lane          = inj;
      v.inj_mask          = mask;
      v.exp.result        = res;
      v.exp.cout          = c;
      v.exp.corrected     = corr;
      v.exp.uncorr        = unc;
      v.exp.op_err        = oe;
      v.exp.lane_failed   = lf;
      v.exp.err_cnt       = ec;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic monitor();
      exp_t got;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && bus.out_valid && bus.out_ready) begin
            got.result      = bus.result;
            got.cout        = bus.cout;
            got.corrected   = bus.corrected;
            got.uncorr      = bus.uncorr;
            got.op_err      = bus.op_err;
            got.lane_failed = lane_failed;
            got.err_cnt     = err_cnt;
            checks++;
            if (sb_q.size() == 0) begin
               failures++;
               $display("FAIL sb_unexpected got res=%h cout=%b", got.result, got.cout);
            end else begin
               e = sb_q.pop_front();
               if (got !== e) begin
                  failures++;
                  $display("FAIL sb_result got res=%h c=%b corr=%b unc=%b oe=%b lf=%b cnt=%0d exp res=%h c=%b corr=%b unc=%b oe=%b lf=%b cnt=%0d",
                           got.result, got.cout, got.corrected, got.uncorr, got.op_err, got.lane_failed, got.err_cnt,
                           e.result, e.cout, e.corrected, e.uncorr, e.op_err, e.lane_failed, e.err_cnt);
               end
            end
         end
      end
   endtask

   task automatic send(input vec_t v);
      int n;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.a        = v.a;
      bus.b        = v.b;
      bus.op       = v.op;
      inj_lane     = v.inj_lane;
      inj_mask     = v.inj_mask;
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!bus.in_ready) begin
         checks++;
         failures++;
         $display("FAIL send_timeout got in_ready=0 exp in_ready=1");
      end else begin
         sb_q.push_back(v.exp);
      end
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      inj_lane     = '0;
      inj_mask     = '0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb_q.size() != 0 || bus.out_valid) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", 64'(sb_q.size()), 64'd0);
   endtask

   initial begin
      logic [9:0] snap;
      vecs[0]  = mk(8'h05, 8'h03, 3'b001, 3'b000, 9'h000, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 8'd0);
      vecs[1]  = mk(8'h05, 8'h03, 3'b010, 3'b000, 9'h000, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 8'd0);
      vecs[2]  = mk(8'h05, 8'h03, 3'b100, 3'b000, 9'h000, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 8'd0);
      vecs[3]  = mk(8'h05, 8'h03, 3'b001, 3'b010, 9'h001, 8'h08, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 8'd1);
      vecs[4]  = mk(8'h10, 8'h20, 3'b001, 3'b000, 9'h000, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 8'd1);
      vecs[5]  = mk(8'hFF, 8'h01, 3'b001, 3'b100, 9'h100, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 8'd2);
      vecs[6]  = mk(8'h80, 8'h80, 3'b001, 3'b100, 9'h100, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 8'd3);
      vecs[7]  = mk(8'h7F, 8'h01, 3'b001, 3'b100, 9'h100, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 8'd4);
      vecs[8]  = mk(8'hAA, 8'h55, 3'b010, 3'b100, 9'h100, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 3'b100, 8'd5);
      vecs[9]  = mk(8'h12, 8'h34, 3'b100, 3'b000, 9'h000, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 8'd5);
      vecs[10] = mk(8'h05, 8'h03, 3'b011, 3'b000, 9'h000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b100, 8'd5);
      vecs[11] = mk(8'h05, 8'h03, 3'b000, 3'b000, 9'h000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b100, 8'd5);
      vecs[12] = mk(8'h05, 8'h03, 3'b001, 3'b011, 9'h001, 8'h09, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 8'd1);
      svec[0]  = mk(8'h01, 8'h02, 3'b001, 3'b000, 9'h000, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 8'd1);
      svec[1]  = mk(8'h0F, 8'hF1, 3'b001, 3'b000, 9'h000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 8'd1);
      svec[2]  = mk(8'h40, 8'h10, 3'b010, 3'b000, 9'h000, 8'h30, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 8'd1);
      svec[3]  = mk(8'h40, 8'h10, 3'b100, 3'b000, 9'h000, 8'hD0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 8'd1);
      svec[4]  = mk(8'hFF, 8'hFF, 3'b001, 3'b000, 9'h000, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 8'd1);

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.op        = '0;
      bus.out_ready = 1'b1;
      inj_lane      = '0;
      inj_mask      = '0;
      clr_fault     = 1'b0;

      fork
         monitor();
      join_none

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_state",
          64'({bus.out_valid, bus.result, bus.cout, bus.corrected, bus.uncorr, bus.op_err, lane_failed, err_cnt, bus.in_ready}),
          64'({1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 1'b1}));
      @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < 12; i++) send(vecs[i]);
      idle();
      drain();

      @(posedge clk);
      #1 clr_fault = 1'b1;
      @(posedge clk);
      #1 clr_fault = 1'b0;
      @(negedge clk);
      chk("clr_fault", 64'({lane_failed, err_cnt}), 64'({3'b000, 8'h00}));

      send(vecs[12]);
      idle();
      drain();

      // Three distinct lane words can only be produced by overriding stage 1 directly.
      send(mk(8'h05, 8'h03, 3'b001, 3'b000, 9'h000, 8'h08, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 8'd1));
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      force dut.s1_w = {9'h00A, 9'h009, 9'h008};
      @(posedge clk);
      #1 release dut.s1_w;
      drain();

      snap = '0;
      fork
         begin
            for (int s = 0; s < 5; s++) send(svec[s]);
            idle();
         end
         begin
            repeat (4) @(posedge clk);
            #1 bus.out_ready = 1'b0;
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
               if (k == 0) begin
                  snap = {bus.out_valid, bus.result, bus.cout};
                  chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
               end else begin
                  chk("stall_hold", 64'({bus.out_valid, bus.result, bus.cout}), 64'(snap));
               end
            end
            @(posedge clk);
            #1 bus.out_ready = 1'b1;
         end
      join
      drain();

      send(svec[0]);
      send(svec[1]);
      send(svec[2]);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      rst          = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_midstream",
          64'({bus.out_valid, bus.result, bus.cout, bus.corrected, bus.uncorr, bus.op_err, lane_failed, err_cnt}),
          64'd0);
      sb_q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_drained", 64'(bus.out_valid), 64'd0);

      for (int k = 1; k <= 260; k++) begin
         send(mk(8'h05, 8'h03, 3'b001, 3'b001, 9'h001, 8'h08, 1'b0, 1'b1, 1'b0, 1'b0,
                 (k >= 4) ? 3'b001 : 3'b000, (k >= 255) ? 8'd255 : 8'(k)));
      end
      idle();
      drain();
      chk("err_cnt_saturated", 64'(err_cnt), 64'd255);
      chk("lane0_failed", 64'(lane_failed), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tmr_alu_pipe.md
Name: tmr_alu_pipe

Overview:
- Pipelined, parametrised triple-modular-redundant ALU: three identical add/subtract lanes, a bitwise majority vote, and registered output with valid/ready handshake.
- Adds per-lane health tracking (consecutive-mismatch FSM), a saturating corrected-error counter, uncorrectable-error detection and a fault-injection port for verification.
- Sits between operand source and result consumer in the dependable datapath; replaces the fixed 3-bit combinational TMR ALU.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- FAIL_THRESH, 4, consecutive mismatches on one lane before it is marked FAILED (>=1).
- CNT_W, 8, width of corrected-error counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands/op valid.
- in_ready  out  1  block accepts when in_valid&in_ready.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  3  one-hot opcode: 001 A+B, 010 A-B, 100 B-A.
- inj_lane  in  3  one-hot-or-zero lane select for fault injection.
- inj_mask  in  WIDTH+1  XOR mask applied to {cout,sum} of selected lanes at stage 1.
- clr_fault  in  1  clears lane_failed, lane states and err_cnt.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts when out_valid&out_ready.
- result  out  WIDTH  voted sum.
- cout  out  1  voted carry-out.
- corrected  out  1  this result had >=1 lane disagreeing with vote, vote still unique.
- uncorr  out  1  no two lanes agree on full {cout,sum}.
- op_err  out  1  op not one-hot for this result.
- lane_failed  out  3  sticky per-lane FAILED flag.
- err_cnt  out  CNT_W  saturating count of corrected results.

Behaviour:
- Reset: out_valid=0, result=0, cout=0, corrected=0, uncorr=0, op_err=0, lane_failed=0, err_cnt=0, all lane FSMs HEALTHY, stage-1 valid=0. in_ready=1 during reset cycle's following cycle onward.
- Arithmetic per lane: 001 -> a+b, cin=0; 010 -> a+~b, cin=1; 100 -> ~a+b, cin=1. Sum WIDTH bits, cout = bit WIDTH of the WIDTH+1 result; no sign extension.
- Illegal op (not exactly one bit set): lanes compute 0 with cout=0; op_err=1 with the result; no counter/FSM update.
- Pipeline: stage 1 registers three lane results (inj_mask XOR applied to lanes selected by inj_lane at capture); stage 2 registers voted word and flags. Latency 2 cycles accept-to-out_valid; throughput 1/cycle.
- Stall: global enable = ~out_valid | out_ready; in_ready = enable. When stalled, both stages and all outputs hold stable.
- Vote: bitwise 2-of-3 over {cout,sum}. Lane mismatch = lane word != voted word. corrected = any mismatch & ~uncorr. uncorr = all three words pairwise unequal; uncorr results neither count nor advance FSMs.
- err_cnt: +1 per corrected result leaving stage 1 into stage 2; saturates at 2^CNT_W-1.
- Lane FSM (per lane, updated when a legal, non-uncorr result advances): HEALTHY: mismatch -> SUSPECT, run=1 (if FAIL_THRESH=1 -> FAILED). SUSPECT: mismatch -> run+1; run reaches FAIL_THRESH -> FAILED; match -> HEALTHY, run=0. FAILED: sticky; lane_failed[i]=1.
- clr_fault: next cycle all FSMs HEALTHY, lane_failed=0, err_cnt=0; if a counted event coincides, clear wins. Pipeline data unaffected.
- rst mid-operation: in-flight data discarded, outputs to reset values next cycle.

Decomposition:
- Package tmr_alu_pkg: opcode constants OP_ADD=3'b001, OP_SUB_AB=3'b010, OP_SUB_BA=3'b100; lane-state enum {HEALTHY, SUSPECT, FAILED}.
- Sub-module tmr_lane_monitor: one lane's FSM and run counter, inputs update/mismatch/clr, output failed; instantiated 3x.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, op=001 -> 2 cycles later result=0x08, cout=0, all flags 0; op=010 -> result=0x02, cout=1; op=100 -> result=0xFE, cout=0.
- inj_lane=010, inj_mask=0x001, a=0x05,b=0x03,op=001 -> result=0x08, corrected=1, err_cnt=1, lane_failed=000.
- inj_lane=100 for 4 consecutive legal ops -> lane_failed=100 with 4th result; then clean ops keep 100; pulse clr_fault -> lane_failed=000, err_cnt=0.
- inj_lane=011 with mask=0x001, then separate test forcing three distinct lane words -> first: result wrong-but-agreeing (corrected=1 on lane 2); second: uncorr=1, err_cnt unchanged.
- op=011 -> op_err=1, result=0x00, cout=0, err_cnt unchanged.
- Stream 5 ops, hold out_ready=0 for 3 cycles -> in_ready=0, result/out_valid stable, no loss/duplication; assert rst mid-stream -> out_valid=0 and flags 0 next cycle.
